inst_rom_sram: RTL and testbench
================================

Name: inst_rom_sram

Overview:
- Word-organised instruction ROM with the codebase's SRAM-like slave interface (req/wr/size/addr/wdata, addr_ok/data_ok/rdata).
- Serves the CPU core's instruction port in simulation benches.
- Contents are preloaded by the bench through hierarchical access to the array `rom` (e.g. $readmemh, per-word clear loops).
- Responses arrive in order after a fixed, parameterised latency. Several requests may be outstanding at once.

Parameters:
- DEPTH, 4096: number of 32-bit words in `rom`; power of two.
- LATENCY, 1: cycles from the accept edge (req & addr_ok) to the data_ok cycle; must be ≥1.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered requests; must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- inst_req  in  1  request valid
- inst_wr  in  1  1 = write request; write data is discarded
- inst_size  in  2  transfer size; ignored, full word always returned
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data; ignored
- inst_rdata  out  32  read data, valid while inst_data_ok=1
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  response valid this cycle

Behaviour:
- Storage:
  - logic [31:0] rom [0:DEPTH-1], named exactly `rom`.
  - Never written by hardware and not cleared by reset; contents survive rst.
- Indexing:
  - index = inst_addr[log2(DEPTH)+1:2].
  - Upper address bits and addr[1:0] are ignored, so kseg addresses such as 0xBFC00000 alias onto word 0.
  - Addresses beyond DEPTH words wrap modulo DEPTH.
- Accept rule:
  - inst_addr_ok = rst & inst_req & (inflight < MAX_OUTSTANDING, or a response retires in this same cycle).
  - Combinational; 0 throughout reset.
  - A request is accepted on a rising edge where inst_req & inst_addr_ok.
- Response timing:
  - An accepted request produces exactly one inst_data_ok pulse LATENCY cycles after acceptance.
  - With LATENCY=1 that is the cycle immediately following the accept edge.
  - Responses are returned in acceptance order.
  - inst_rdata = rom[index], registered from the index captured at accept time.
- Writes:
  - Accepted like reads and return data_ok with the same timing.
  - rdata = current rom[index]; rom is unchanged.
- Pipeline:
  - Implement as a LATENCY-deep shift register of {valid, index}, plus an inflight counter (width clog2(MAX_OUTSTANDING+1)).
  - Increment on accept, decrement on data_ok; simultaneous accept and retire leave the counter unchanged.
  - Counter never exceeds MAX_OUTSTANDING and never underflows.
- Throughput: with LATENCY=1 and MAX_OUTSTANDING≥1, a continuously asserted req is accepted every cycle, giving one word per cycle.
- Reset (asynchronous, on rst=0):
  - Pipeline valids, inflight, inst_data_ok and inst_rdata all go to 0.
  - Requests in flight when reset asserts are dropped with no data_ok.
  - First accept is possible on the first rising edge with rst=1.
- Undriven/X inputs while req=0 have no effect.

Decomposition:
- Shared package `sram_like_pkg`:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD = 2'd0/1/2;
  - typedef for an sram-like request struct {req, wr, size, addr, wdata};
  - typedef for a response struct {addr_ok, data_ok, rdata}.
- No sub-module needed; the latency pipe is inline.

Test Plan:
- Reset: rst=0 for 5 cycles with req=1 → addr_ok=0, data_ok=0, rdata=0. On release with rom[0]=0x3401FFFF, addr=0 → data_ok next cycle, rdata=0x3401FFFF.
- Streaming: rom[i]=i*0x11111111 for i=0..3, req held, addr 0,4,8,12 on consecutive cycles (LATENCY=1) → 4 consecutive data_ok, rdata 0x00000000, 0x11111111, 0x22222222, 0x33333333, in order.
- Aliasing/wrap: addr=0xBFC00004 → rom[1]; addr=DEPTH*4+8 → rom[2]; addr=0x00000006 → rom[1].
- Outstanding limit: LATENCY=4, MAX_OUTSTANDING=2, req held → addr_ok high 2 cycles, low until first data_ok, then high again; total data_ok count equals accept count.
- Write ignored: wr=1, addr=8, wdata=0xDEADBEEF with rom[2]=0x12345678 → data_ok with rdata 0x12345678; a subsequent read of addr 8 still returns 0x12345678.
- Reset mid-operation: LATENCY=3, accept 2 requests, assert rst before any data_ok → no data_ok ever appears for them; after release a new read returns the correct word after 3 cycles.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like slave bus (req/wr/size/addr/wdata, addr_ok/data_ok/rdata).
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
    } sram_rsp_t;

endpackage

// File: rtl/inst_rom_sram.sv
// Word-organised instruction ROM behind an SRAM-like slave port with fixed, in-order latency
// and a bounded number of outstanding requests. Contents are preloaded through `rom`.
module inst_rom_sram
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH           = 4096,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MaxOut = CW'(MAX_OUTSTANDING);

    logic [31:0] rom [0:DEPTH-1];

    sram_req_t bus_req;
    sram_rsp_t bus_rsp;

    logic          accept;
    logic          retire;
    logic [AW-1:0] acc_idx;
    logic          out_v;
    logic [AW-1:0] out_idx;

    logic          data_ok_q;
    logic [31:0]   rdata_q;
    logic [CW-1:0] inflight_q, inflight_d;

    assign bus_req = '{req:   inst_req,
                       wr:    inst_wr,
                       size:  inst_size,
                       addr:  inst_addr,
                       wdata: inst_wdata};

    // Writes are answered like reads; size, write data and out-of-range address bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{bus_req.wr, bus_req.size, bus_req.wdata,
                           bus_req.addr[31:AW+2], bus_req.addr[1:0]};

    assign acc_idx = bus_req.addr[AW+1:2];
    assign retire  = data_ok_q;
    assign accept  = rst & bus_req.req & ((inflight_q < MaxOut) | retire);

    if (LATENCY > 1) begin : g_pipe
        logic [LATENCY-2:0] v_q;
        logic [AW-1:0]      idx_q [LATENCY-1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= '0;
            end else begin
                v_q[0] <= accept;
                for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                    v_q[i] <= v_q[i-1];
                end
            end
        end

        // Index lanes carry no state of their own; the valid bits qualify them.
        always_ff @(posedge clk) begin
            idx_q[0] <= acc_idx;
            for (int i = 1; i < int'(LATENCY) - 1; i++) begin
                idx_q[i] <= idx_q[i-1];
            end
        end

        assign out_v   = v_q[LATENCY-2];
        assign out_idx = idx_q[LATENCY-2];
    end else begin : g_direct
        assign out_v   = accept;
        assign out_idx = acc_idx;
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, retire})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_ok_q  <= 1'b0;
            rdata_q    <= '0;
            inflight_q <= '0;
        end else begin
            data_ok_q  <= out_v;
            inflight_q <= inflight_d;
            if (out_v) begin
                rdata_q <= rom[out_idx];
            end
        end
    end

    assign bus_rsp = '{addr_ok: accept, data_ok: data_ok_q, rdata: rdata_q};

    assign inst_addr_ok = bus_rsp.addr_ok;
    assign inst_data_ok = bus_rsp.data_ok;
    assign inst_rdata   = bus_rsp.rdata;

endmodule

// File: tb/tb_inst_rom_sram.sv
// Bench for inst_rom_sram: three configurations driven in lockstep, checked each cycle
// against a queue-based timing model, plus literal checks of the directed scenarios.
module tb_inst_rom_sram;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [2:0]       aok;
    logic [2:0]       dok;
    logic [2:0][31:0] rd;

    inst_rom_sram #(.DEPTH(4096), .LATENCY(1), .MAX_OUTSTANDING(2)) dut1 (
        .clk(clk), .rst(rst), .inst_req(req), .inst_wr(wr), .inst_size(size),
        .inst_addr(addr), .inst_wdata(wdata), .inst_rdata(rd[0]),
        .inst_addr_ok(aok[0]), .inst_data_ok(dok[0])
    );

    inst_rom_sram #(.DEPTH(4096), .LATENCY(4), .MAX_OUTSTANDING(2)) dut4 (
        .clk(clk), .rst(rst), .inst_req(req), .inst_wr(wr), .inst_size(size),
        .inst_addr(addr), .inst_wdata(wdata), .inst_rdata(rd[1]),
        .inst_addr_ok(aok[1]), .inst_data_ok(dok[1])
    );

    inst_rom_sram #(.DEPTH(256), .LATENCY(3), .MAX_OUTSTANDING(3)) dut3 (
        .clk(clk), .rst(rst), .inst_req(req), .inst_wr(wr), .inst_size(size),
        .inst_addr(addr), .inst_wdata(wdata), .inst_rdata(rd[2]),
        .inst_addr_ok(aok[2]), .inst_data_ok(dok[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned lat [3] = '{1, 4, 3};
    int unsigned mo  [3] = '{2, 2, 3};
    int unsigned dep [3] = '{4096, 4096, 256};

    logic [31:0] mem [0:4095];

    typedef struct {
        int          inst;
        int unsigned due;
        int unsigned idx;
    } ent_t;
    ent_t pq[$];

    int errs   = 0;
    int checks = 0;
    int unsigned cyc = 0;

    int unsigned acc_cnt [3] = '{0, 0, 0};
    int unsigned dok_cnt [3] = '{0, 0, 0};
    logic [31:0] got1[$];
    int unsigned gotc1[$];
    logic [31:0] got3[$];
    int unsigned gotc3[$];
    int unsigned acc3c[$];
    logic        log4[$];
    logic        rec4 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setw(input int i, input logic [31:0] v);
        mem[i] = v;
        dut1.rom[i] = v;
        dut4.rom[i] = v;
        if (i < 256) dut3.rom[i] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle model: each accepted request is due exactly LATENCY cycles later, in order.
    always @(negedge clk) begin
        int   n;
        int   hpos;
        logic edok;
        logic eaok;
        logic [31:0] erd;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            hpos = -1;
            for (int j = 0; j < pq.size(); j++) begin
                if (pq[j].inst == k) begin
                    if (hpos < 0) hpos = j;
                    n++;
                end
            end
            edok = rst && (hpos >= 0) && (pq[hpos].due == cyc);
            eaok = rst && req && ((n < int'(mo[k])) || edok);
            erd  = edok ? mem[pq[hpos].idx] : 32'h0;
            chk($sformatf("addr_ok[%0d]", k), {31'b0, aok[k]}, {31'b0, eaok});
            chk($sformatf("data_ok[%0d]", k), {31'b0, dok[k]}, {31'b0, edok});
            if (!rst || edok) chk($sformatf("rdata[%0d]", k), rd[k], erd);
            if (edok) pq.delete(hpos);
            if (eaok) pq.push_back('{k, cyc + lat[k], (addr >> 2) % dep[k]});
            if (aok[k] && req) acc_cnt[k]++;
            if (dok[k]) dok_cnt[k]++;
        end
        if (!rst) pq.delete();
        if (dok[0]) begin
            got1.push_back(rd[0]);
            gotc1.push_back(cyc);
        end
        if (dok[2]) begin
            got3.push_back(rd[2]);
            gotc3.push_back(cyc);
        end
        if (aok[2] && req) acc3c.push_back(cyc);
        if (rec4) log4.push_back(aok[1]);
        cyc++;
    end

    initial begin
        logic [31:0] exp_stream [4];
        logic        exp_pat [12];
        int unsigned a0;
        int unsigned d0;
        exp_stream = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
        exp_pat    = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = '0; wdata = '0;
        for (int i = 0; i < 4096; i++) setw(i, $urandom());
        setw(0, 32'h3401FFFF);

        // Reset held with req asserted, then a single read of word 0.
        #1;
        rst = 1'b0; req = 1'b1; addr = 32'h0;
        repeat (5) step();
        rst = 1'b1;
        step();
        req = 1'b0;
        repeat (6) step();
        chk("reset_first_count", got1.size(), 1);
        if (got1.size() >= 1) chk("reset_first_word", got1[0], 32'h3401FFFF);

        // Streaming, one word per cycle on the LATENCY=1 port.
        for (int i = 0; i < 4; i++) setw(i, i * 32'h11111111);
        got1.delete(); gotc1.delete();
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = i * 4;
            step();
        end
        req = 1'b0;
        repeat (8) step();
        chk("stream_count", got1.size(), 4);
        if (got1.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("stream_word%0d", i), got1[i], exp_stream[i]);
                chk($sformatf("stream_cycle%0d", i), gotc1[i] - gotc1[0], i);
            end
        end

        // Aliasing of upper/low address bits and wrap beyond DEPTH.
        setw(1, 32'hA1A1A1A1);
        setw(2, 32'hB2B2B2B2);
        got1.delete();
        req = 1'b1;
        addr = 32'hBFC00004; step();
        addr = 4096 * 4 + 8; step();
        addr = 32'h00000006; step();
        req = 1'b0;
        repeat (8) step();
        chk("alias_count", got1.size(), 3);
        if (got1.size() == 3) begin
            chk("alias_kseg", got1[0], 32'hA1A1A1A1);
            chk("alias_wrap", got1[1], 32'hB2B2B2B2);
            chk("alias_lowbits", got1[2], 32'hA1A1A1A1);
        end

        // Outstanding limit on the LATENCY=4, MAX_OUTSTANDING=2 port.
        log4.delete();
        rec4 = 1'b1; req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            addr = $urandom();
            step();
        end
        rec4 = 1'b0; req = 1'b0;
        repeat (8) step();
        chk("limit_log_len", log4.size(), 12);
        if (log4.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk($sformatf("limit_addr_ok%0d", i), {31'b0, log4[i]}, {31'b0, exp_pat[i]});
            end
        end
        chk("limit_balance", dok_cnt[1], acc_cnt[1]);

        // Writes are answered with the stored word and leave the ROM unchanged.
        setw(2, 32'h12345678);
        got1.delete();
        req = 1'b1; wr = 1'b1; addr = 32'h8; wdata = 32'hDEADBEEF;
        step();
        wr = 1'b0;
        step();
        req = 1'b0;
        repeat (6) step();
        chk("write_count", got1.size(), 2);
        if (got1.size() == 2) begin
            chk("write_rdata", got1[0], 32'h12345678);
            chk("write_readback", got1[1], 32'h12345678);
        end
        chk("write_rom_kept", dut1.rom[2], 32'h12345678);

        // Reset while two requests are in flight on the LATENCY=3 port.
        a0 = acc_cnt[2];
        d0 = dok_cnt[2];
        req = 1'b1;
        addr = 32'd16; step();
        addr = 32'd20; step();
        rst = 1'b0; req = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        repeat (3) step();
        chk("midreset_accepts", acc_cnt[2] - a0, 2);
        chk("midreset_no_data_ok", dok_cnt[2] - d0, 0);
        setw(5, 32'hCAFEF00D);
        got3.delete(); gotc3.delete(); acc3c.delete();
        req = 1'b1; addr = 32'd20;
        step();
        req = 1'b0;
        repeat (6) step();
        chk("midreset_count", got3.size(), 1);
        if (got3.size() == 1 && acc3c.size() == 1) begin
            chk("midreset_word", got3[0], 32'hCAFEF00D);
            chk("midreset_latency", gotc3[0] - acc3c[0], 3);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            req   = ($urandom_range(0, 9) < 7);
            wr    = $urandom_range(0, 1) == 1;
            size  = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 63) * 4);
            wdata = $urandom();
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                step();
                step();
                rst = 1'b1;
            end
            step();
        end
        req = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
